// File: rtl/csa_pkg.sv
// -----------------------------------------------------------------------------
// csa_pkg
// Shared constants for the pipelined carry-skip adder: default geometry
// (operand width, carry-skip group size, pipeline depth) and the add/subtract
// mode encoding seen on the adder's `sub` input.
// -----------------------------------------------------------------------------
package csa_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_SKIP   = 4;
    localparam int DEF_STAGES = 2;

    typedef enum logic {
        ADD = 1'b0,
        SUB = 1'b1
    } mode_e;

endpackage

// File: rtl/skip_group.sv
// -----------------------------------------------------------------------------
// skip_group
// One carry-skip group: a W-bit ripple-carry chain whose carry-out is taken
// directly from the carry-in when every bit of the group propagates.
//
// Ports
//   a_i, b_i : group operand bits (b already inverted for subtraction)
//   c_i      : carry into the group
//   s_o      : group sum bits
//   c_o      : carry out of the group (bypassed when all propagate bits are 1)
// -----------------------------------------------------------------------------
module skip_group #(
    parameter int W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         c_i,
    output logic [W-1:0] s_o,
    output logic         c_o
);

    logic [W-1:0] prop;
    logic [W-1:0] gen;
    logic [W:0]   rc;

    always_comb begin
        prop  = a_i ^ b_i;
        gen   = a_i & b_i;
        rc    = '0;
        rc[0] = c_i;
        for (int i = 0; i < W; i++) begin
            rc[i+1] = gen[i] | (prop[i] & rc[i]);
        end
        s_o = prop ^ rc[W-1:0];
        // When the whole group propagates, the incoming carry skips the ripple.
        c_o = (&prop) ? c_i : rc[W];
    end

endmodule

// File: rtl/pipelined_skip_adder.sv
// -----------------------------------------------------------------------------
// pipelined_skip_adder
// WIDTH-bit add/subtract unit split into STAGES segments of SEG = WIDTH/STAGES
// bits. Each segment is a chain of SKIP-bit carry-skip groups; the carry out of
// segment k is registered and feeds segment k+1 one cycle later. Upper operand
// bits travel down the pipe with the transaction and finished low sum bits are
// carried along, so every bit of a result leaves the last register together.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   a, b                : operands
//   cin                 : carry in (add mode only)
//   sub                 : 0 = add, 1 = subtract (a + ~b + 1)
//   in_valid / in_ready : operand handshake; in_ready = !out_valid || out_ready
//   sum, cout, ovf      : result, carry out of MSB, signed overflow
//   out_valid/out_ready : result handshake
// -----------------------------------------------------------------------------
module pipelined_skip_adder
    import csa_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int SKIP   = DEF_SKIP,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int NGRP = SEG / SKIP;
    localparam int LAST = STAGES - 1;

    if ((WIDTH % (STAGES * SKIP)) != 0) begin : g_bad_cfg
        $error("pipelined_skip_adder: WIDTH must be a multiple of STAGES*SKIP");
    end

    // Inputs seen by each stage's segment adder.
    logic [WIDTH-1:0] stg_a [STAGES];
    logic [WIDTH-1:0] stg_b [STAGES];
    logic [WIDTH-1:0] stg_s [STAGES];
    logic             stg_c [STAGES];
    logic             stg_v [STAGES];

    // Segment adder outputs.
    logic [SEG-1:0]   seg_s  [STAGES];
    logic             seg_co [STAGES];

    // Pipeline registers: index k is the register at the end of stage k.
    logic [WIDTH-1:0] opa_d [STAGES], opa_q [STAGES];
    logic [WIDTH-1:0] opb_d [STAGES], opb_q [STAGES];
    logic [WIDTH-1:0] sum_d [STAGES], sum_q [STAGES];
    logic             car_d [STAGES], car_q [STAGES];
    logic             vld_d [STAGES], vld_q [STAGES];

    logic adv;

    // The whole pipe moves as one; a stalled output freezes every stage.
    assign adv      = !vld_q[LAST] || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_in
            // Subtraction is folded in here: invert b and force the carry in.
            assign stg_a[k] = a;
            assign stg_b[k] = (sub == SUB) ? ~b : b;
            assign stg_c[k] = (sub == SUB) ? 1'b1 : cin;
            assign stg_s[k] = '0;
            assign stg_v[k] = in_valid;
        end else begin : g_link
            assign stg_a[k] = opa_q[k-1];
            assign stg_b[k] = opb_q[k-1];
            assign stg_c[k] = car_q[k-1];
            assign stg_s[k] = sum_q[k-1];
            assign stg_v[k] = vld_q[k-1];
        end

        logic [NGRP:0]  gc;
        logic [SEG-1:0] ss;

        assign gc[0] = stg_c[k];

        for (genvar g = 0; g < NGRP; g++) begin : g_grp
            skip_group #(.W(SKIP)) u_grp (
                .a_i (stg_a[k][k*SEG + g*SKIP +: SKIP]),
                .b_i (stg_b[k][k*SEG + g*SKIP +: SKIP]),
                .c_i (gc[g]),
                .s_o (ss[g*SKIP +: SKIP]),
                .c_o (gc[g+1])
            );
        end

        assign seg_s[k]  = ss;
        assign seg_co[k] = gc[NGRP];
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            opa_d[k] = stg_a[k];
            opb_d[k] = stg_b[k];
            sum_d[k] = stg_s[k];
            sum_d[k][k*SEG +: SEG] = seg_s[k];
            car_d[k] = seg_co[k];
            vld_d[k] = stg_v[k];
        end
    end

    // ---- stage registers (segment k result, carry, delayed operands) ----
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                opa_q[k] <= '0;
                opb_q[k] <= '0;
                sum_q[k] <= '0;
                car_q[k] <= 1'b0;
                vld_q[k] <= 1'b0;
            end
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                opa_q[k] <= opa_d[k];
                opb_q[k] <= opb_d[k];
                sum_q[k] <= sum_d[k];
                car_q[k] <= car_d[k];
                vld_q[k] <= vld_d[k];
            end
        end
    end

    // ---- output ----
    // Overflow uses the effective operand signs that travelled with the result;
    // all three bits clear on reset, so ovf reads 0 after reset as well.
    assign sum       = sum_q[LAST];
    assign cout      = car_q[LAST];
    assign out_valid = vld_q[LAST];
    assign ovf       = (opa_q[LAST][WIDTH-1] == opb_q[LAST][WIDTH-1]) &&
                       (sum_q[LAST][WIDTH-1] != opa_q[LAST][WIDTH-1]);

endmodule

// File: tb/tb_pipelined_skip_adder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_skip_adder
// Three adder configurations run side by side on one clock. Accepted operands
// are turned into expected results by a plain-arithmetic model and queued; a
// monitor pops and compares whenever a result is consumed. The default
// configuration also runs directed corner, stall and reset cases.
// -----------------------------------------------------------------------------
module tb_pipelined_skip_adder;

    int n_cmp = 0;
    int n_bad = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar ci = 0; ci < 3; ci++) begin : g_cfg
        localparam int W  = (ci == 0) ? 32 : (ci == 1) ? 16 : 64;
        localparam int SK = (ci == 2) ? 8 : 4;
        localparam int ST = (ci == 0) ? 2 : (ci == 1) ? 1 : 4;

        typedef struct {
            logic [W-1:0] s;
            logic         co;
            logic         ov;
        } exp_t;

        logic         rst;
        logic [W-1:0] a, b;
        logic         cin, sub, in_valid, in_ready;
        logic [W-1:0] sum;
        logic         cout, ovf, out_valid, out_ready;

        exp_t         exp_q [$];
        exp_t         e;
        int           acc_n  = 0;
        bit           fin    = 1'b0;
        bit           held_v = 1'b0;
        logic [W-1:0] held_s;
        logic         held_c, held_o;

        pipelined_skip_adder #(.WIDTH(W), .SKIP(SK), .STAGES(ST)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .a         (a),
            .b         (b),
            .cin       (cin),
            .sub       (sub),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .sum       (sum),
            .cout      (cout),
            .ovf       (ovf),
            .out_valid (out_valid),
            .out_ready (out_ready)
        );

        function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic c, input logic s);
            logic [W-1:0] ye;
            logic [W:0]   t;
            exp_t         r;
            ye   = s ? ~y : y;
            t    = {1'b0, x} + {1'b0, ye} + (W+1)'(s ? 1'b1 : c);
            r.s  = t[W-1:0];
            r.co = t[W];
            r.ov = (x[W-1] == ye[W-1]) && (t[W-1] != x[W-1]);
            return r;
        endfunction

        function automatic logic [W-1:0] pick();
            case ($urandom_range(0, 7))
                0:       return '0;
                1:       return '1;
                2:       return {1'b0, {(W-1){1'b1}}};
                3:       return {1'b1, {(W-1){1'b0}}};
                default: return W'({$urandom, $urandom});
            endcase
        endfunction

        task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL cfg%0d %s: got %h, want %h", ci, nm, got, want);
            end
        endtask

        // Scoreboard push: operands accepted at the coming edge.
        initial forever begin
            @(negedge clk);
            if (!rst && in_valid && in_ready) begin
                exp_q.push_back(model(a, b, cin, sub));
                acc_n++;
            end
        end

        // A reset edge discards everything in flight.
        initial forever begin
            @(posedge clk);
            if (rst) exp_q.delete();
        end

        // Monitor: handshake rule, output stability under stall, result order.
        initial forever begin
            @(negedge clk);
            if (rst) begin
                held_v = 1'b0;
            end else begin
                chk("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
                if (held_v) begin
                    chk("hold_valid", 64'(out_valid), 64'd1);
                    chk("hold_sum", 64'(sum), 64'(held_s));
                    chk("hold_flags", 64'({cout, ovf}), 64'({held_c, held_o}));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL cfg%0d unexpected_result: got sum %h, no result outstanding", ci, sum);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sum", 64'(sum), 64'(e.s));
                        chk("cout_ovf", 64'({cout, ovf}), 64'({e.co, e.ov}));
                    end
                end
                held_v = out_valid && !out_ready;
                held_s = sum;
                held_c = cout;
                held_o = ovf;
            end
        end

        task automatic tx(input logic [63:0] x, input logic [63:0] y, input logic c, input logic s);
            bit ok;
            ok       = 1'b0;
            a        = x[W-1:0];
            b        = y[W-1:0];
            cin      = c;
            sub      = s;
            in_valid = 1'b1;
            for (int i = 0; i < 50 && !ok; i++) begin
                @(negedge clk);
                ok = in_ready;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b0;
            if (!ok) chk("accept_timeout", 64'd0, 64'd1);
        endtask

        task automatic dtx(input logic [63:0] x, input logic [63:0] y, input logic c, input logic s,
                           input logic [63:0] es, input logic eco, input logic eov, input string nm);
            int n;
            tx(x, y, c, s);
            n = 1;
            while (!out_valid && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk({nm, "_latency"}, 64'(n), 64'(ST));
            chk({nm, "_sum"}, 64'(sum), es);
            chk({nm, "_cout"}, 64'(cout), 64'(eco));
            chk({nm, "_ovf"}, 64'(ovf), 64'(eov));
        endtask

        task automatic drain();
            out_ready = 1'b1;
            in_valid  = 1'b0;
            for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
                @(posedge clk);
                #1;
            end
            chk("drain_empty", 64'(exp_q.size()), 64'd0);
        endtask

        task automatic run_directed();
            int seen;
            out_ready = 1'b1;
            dtx(64'hFFFFFFFF, 64'h0, 1'b1, 1'b0, 64'h00000000, 1'b1, 1'b0, "wrap");
            dtx(64'h5, 64'h7, 1'b0, 1'b1, 64'hFFFFFFFE, 1'b0, 1'b0, "sub_neg");
            dtx(64'h7, 64'h5, 1'b1, 1'b1, 64'h00000002, 1'b1, 1'b0, "sub_pos");
            dtx(64'h7FFFFFFF, 64'h1, 1'b0, 1'b0, 64'h80000000, 1'b0, 1'b1, "ovf_add");
            dtx(64'h80000000, 64'h1, 1'b0, 1'b1, 64'h7FFFFFFF, 1'b1, 1'b1, "ovf_sub");
            dtx(64'h0F0F0F0F, 64'hF0F0F0F0, 1'b1, 1'b0, 64'h00000000, 1'b1, 1'b0, "all_prop");

            // Three back-to-back, output stalled for two cycles after the first result.
            tx(64'h11, 64'h22, 1'b0, 1'b0);
            tx(64'h33, 64'h44, 1'b1, 1'b0);
            out_ready = 1'b0;
            a         = W'(64'h55);
            b         = W'(64'h66);
            cin       = 1'b0;
            sub       = 1'b1;
            in_valid  = 1'b1;
            repeat (2) begin
                @(negedge clk);
                chk("stall_in_ready", 64'(in_ready), 64'd0);
                chk("stall_first_sum", 64'(sum), 64'h33);
                @(posedge clk);
                #1;
            end
            out_ready = 1'b1;
            tx(64'h55, 64'h66, 1'b0, 1'b1);
            drain();

            // Reset with two transactions in flight.
            tx(64'hAAAA5555, 64'h1, 1'b0, 1'b0);
            out_ready = 1'b0;
            tx(64'h1234, 64'h4321, 1'b0, 1'b0);
            rst      = 1'b1;
            in_valid = 1'b0;
            @(posedge clk);
            #1;
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_sum", 64'(sum), 64'd0);
            chk("rst_flags", 64'({cout, ovf}), 64'd0);
            chk("rst_in_ready", 64'(in_ready), 64'd1);
            rst       = 1'b0;
            out_ready = 1'b1;
            seen      = 0;
            repeat (10) begin
                @(posedge clk);
                #1;
                if (out_valid) seen++;
            end
            chk("rst_flushed", 64'(seen), 64'd0);
        endtask

        initial begin
            int cyc;
            rst       = 1'b1;
            a         = '0;
            b         = '0;
            cin       = 1'b0;
            sub       = 1'b0;
            in_valid  = 1'b0;
            out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            chk("reset_out_valid", 64'(out_valid), 64'd0);
            chk("reset_sum", 64'(sum), 64'd0);
            chk("reset_flags", 64'({cout, ovf}), 64'd0);
            chk("reset_in_ready", 64'(in_ready), 64'd1);
            rst = 1'b0;

            if (ci == 0) run_directed();

            cyc = 0;
            while (acc_n < 10000 && cyc < 60000) begin
                a         = pick();
                b         = pick();
                cin       = 1'($urandom);
                sub       = 1'($urandom);
                in_valid  = ($urandom % 4) != 0;
                out_ready = ($urandom % 4) != 0;
                @(posedge clk);
                #1;
                cyc++;
            end
            chk("random_count_reached", 64'(acc_n >= 10000), 64'd1);
            drain();
            fin = 1'b1;
        end
    end

    initial begin
        int t;
        t = 0;
        while (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin) && t < 150000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 150000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL global_timeout: got %0d cycles, want completion", t);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
